// File: rtl/kb_echo_ctrl_if.sv
// Handshake bundle between the echo controller, the keyboard scan-code FIFO
// and the UART transmit FIFO.
interface kb_echo_ctrl_if;
    logic       kb_buf_empty;
    logic [7:0] ascii_code;
    logic       rd_key_code;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       busy;
    logic [6:0] col;

    modport master (
        input  kb_buf_empty,
        input  ascii_code,
        input  tx_full,
        output rd_key_code,
        output wr_uart,
        output w_data,
        output busy,
        output col
    );

    modport slave (
        output kb_buf_empty,
        output ascii_code,
        output tx_full,
        input  rd_key_code,
        input  wr_uart,
        input  w_data,
        input  busy,
        input  col
    );
endinterface

// File: rtl/kb_echo_ctrl.sv
// Keyboard echo controller: pops one ASCII key at a time and echoes it to the
// UART transmit FIFO with automatic line wrap, Enter and Backspace handling.
module kb_echo_ctrl #(
    parameter int unsigned MAX_COL = 80
) (
    input  logic           clk,
    input  logic           reset,
    kb_echo_ctrl_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [6:0] MAX_COL_C = 7'(MAX_COL);
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_TILDE  = 8'h7E;

    logic [1:0]      state_q,   state_d;
    logic [7:0]      key_q,     key_d;
    logic [4:0][7:0] seq_q,     seq_d;
    logic [2:0]      len_q,     len_d;
    logic [2:0]      idx_q,     idx_d;
    logic [6:0]      col_q,     col_d;
    logic [6:0]      col_nxt_q, col_nxt_d;
    logic            rd_q,      rd_d;
    logic            busy_q,    busy_d;
    logic            vld_q,     vld_d;
    logic [7:0]      wdata_q,   wdata_d;

    logic [4:0][7:0] cls_seq_s;
    logic [2:0]      cls_len_s;
    logic [6:0]      cls_col_s;
    logic            accept_s;

    // Translate the latched key into its echo byte sequence and resulting column.
    always_comb begin
        cls_seq_s = '0;
        cls_len_s = 3'd0;
        cls_col_s = col_q;
        if (key_q >= CH_SP && key_q <= CH_TILDE) begin
            if (col_q < MAX_COL_C) begin
                cls_seq_s[0] = key_q;
                cls_len_s    = 3'd1;
                cls_col_s    = col_q + 7'd1;
            end else begin
                cls_seq_s[0] = CH_CR;
                cls_seq_s[1] = CH_LF;
                cls_seq_s[2] = key_q;
                cls_len_s    = 3'd3;
                cls_col_s    = 7'd1;
            end
        end else if (key_q == CH_CR) begin
            cls_seq_s[0] = CH_CR;
            cls_seq_s[1] = CH_LF;
            cls_len_s    = 3'd2;
            cls_col_s    = 7'd0;
        end else if (key_q == CH_BS && col_q != 7'd0) begin
            cls_seq_s[0] = CH_BS;
            cls_seq_s[1] = CH_SP;
            cls_seq_s[2] = CH_BS;
            cls_len_s    = 3'd3;
            cls_col_s    = col_q - 7'd1;
        end else begin
            cls_len_s = 3'd0;
        end
    end

    // A staged byte is only handed over in a cycle where the UART FIFO has room.
    assign accept_s = vld_q & ~bus.tx_full;

    // Sequencer next-state: one key in flight, sequence bytes shifted out of seq_q.
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        seq_d     = seq_q;
        len_d     = len_q;
        idx_d     = idx_q;
        col_d     = col_q;
        col_nxt_d = col_nxt_q;
        rd_d      = 1'b0;
        busy_d    = busy_q;
        vld_d     = vld_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.kb_buf_empty) begin
                    key_d   = bus.ascii_code;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                seq_d     = cls_seq_s;
                len_d     = cls_len_s;
                idx_d     = 3'd0;
                col_nxt_d = cls_col_s;
                vld_d     = 1'b0;
                if (cls_len_s == 3'd0) begin
                    col_d   = cls_col_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (!vld_q) begin
                    wdata_d = seq_q[0];
                    seq_d   = {8'h00, seq_q[4:1]};
                    vld_d   = 1'b1;
                end else if (accept_s) begin
                    if (idx_q == len_q - 3'd1) begin
                        vld_d   = 1'b0;
                        wdata_d = 8'h00;
                        idx_d   = 3'd0;
                        col_d   = col_nxt_q;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        wdata_d = seq_q[0];
                        seq_d   = {8'h00, seq_q[4:1]};
                    end
                end else begin
                    wdata_d = wdata_q;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            key_q     <= 8'h00;
            seq_q     <= '0;
            len_q     <= 3'd0;
            idx_q     <= 3'd0;
            col_q     <= 7'd0;
            col_nxt_q <= 7'd0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            vld_q     <= 1'b0;
            wdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            seq_q     <= seq_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            col_q     <= col_d;
            col_nxt_q <= col_nxt_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            vld_q     <= vld_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.rd_key_code = rd_q;
    assign bus.wr_uart     = accept_s;
    assign bus.w_data      = wdata_q;
    assign bus.busy        = busy_q;
    assign bus.col         = col_q;

endmodule

// File: tb/tb_kb_echo_ctrl.sv
// Bench for kb_echo_ctrl: two instances (MAX_COL 4 and 80) fed the same keys,
// each checked against a per-key echo model and its own keyboard FIFO model.
module tb_kb_echo_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    kb_echo_ctrl_if if4 ();
    kb_echo_ctrl_if if80 ();

    kb_echo_ctrl #(.MAX_COL(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));
    kb_echo_ctrl #(.MAX_COL(80)) dut80 (.clk(clk), .reset(reset), .bus(if80));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        int         col4;
        int         col80;
        int         w4;
        int         w80;
    } vec_t;

    vec_t       vt [22];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    int         maxc [2] = '{4, 80};
    logic [7:0] kbbuf [2][4096];
    logic [7:0] expbuf [2][8192];
    int         kb_wr [2], kb_rd [2], ex_wr [2], ex_rd [2], col_m [2];
    int         rd_cyc [2], wr_idx [2], rd_cnt [2], wr_cnt [2];
    bit         pop_pend [2], prev_busy [2];
    bit         lat_en;
    int         tx_mode;
    logic       tx_full_v;

    function automatic logic o_wr(input int d);
        return (d == 0) ? if4.wr_uart : if80.wr_uart;
    endfunction
    function automatic logic o_rd(input int d);
        return (d == 0) ? if4.rd_key_code : if80.rd_key_code;
    endfunction
    function automatic logic o_busy(input int d);
        return (d == 0) ? if4.busy : if80.busy;
    endfunction
    function automatic logic [7:0] o_wdata(input int d);
        return (d == 0) ? if4.w_data : if80.w_data;
    endfunction
    function automatic logic [6:0] o_col(input int d);
        return (d == 0) ? if4.col : if80.col;
    endfunction

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (MAX_COL=%0d, cycle %0d): got %0d (0x%0h), expected %0d (0x%0h)",
                      name, maxc[d], cyc, act, act, exp, exp);
    endtask

    task automatic push_exp(input int d, input logic [7:0] b);
        expbuf[d][ex_wr[d]] = b;
        ex_wr[d]++;
    endtask

    // Echo rules applied to one consumed key.
    task automatic model_key(input int d, input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            if (col_m[d] < maxc[d]) begin
                push_exp(d, k);
                col_m[d]++;
            end else begin
                push_exp(d, 8'h0D); push_exp(d, 8'h0A); push_exp(d, k);
                col_m[d] = 1;
            end
        end else if (k == 8'h0D) begin
            push_exp(d, 8'h0D); push_exp(d, 8'h0A);
            col_m[d] = 0;
        end else if (k == 8'h08 && col_m[d] > 0) begin
            push_exp(d, 8'h08); push_exp(d, 8'h20); push_exp(d, 8'h08);
            col_m[d]--;
        end
    endtask

    task automatic push_key(input logic [7:0] k);
        for (int d = 0; d < 2; d++) begin
            kbbuf[d][kb_wr[d]] = k;
            kb_wr[d]++;
        end
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5)      return 8'($urandom_range(32, 126));
        else if (r == 6) return 8'h0D;
        else if (r <= 8) return 8'h08;
        else             return 8'($urandom_range(0, 255));
    endfunction

    task automatic drive();
        case (tx_mode)
            0:       tx_full_v = 1'b0;
            1:       tx_full_v = 1'b1;
            default: tx_full_v = ($urandom_range(0, 99) < 30);
        endcase
        if4.tx_full       = tx_full_v;
        if80.tx_full      = tx_full_v;
        if4.kb_buf_empty  = (kb_rd[0] >= kb_wr[0]);
        if80.kb_buf_empty = (kb_rd[1] >= kb_wr[1]);
        if4.ascii_code    = (kb_rd[0] < kb_wr[0]) ? kbbuf[0][kb_rd[0]] : 8'h00;
        if80.ascii_code   = (kb_rd[1] < kb_wr[1]) ? kbbuf[1][kb_rd[1]] : 8'h00;
    endtask

    task automatic mon(input int d);
        logic wr, rd, bz;
        wr = o_wr(d);
        rd = o_rd(d);
        bz = o_busy(d);
        if (wr) begin
            chk("wr_while_tx_full", d, int'(tx_full_v), 0);
            chk("wr_expected", d, int'(ex_rd[d] < ex_wr[d]), 1);
            if (ex_rd[d] < ex_wr[d]) begin
                chk("w_data", d, int'(o_wdata(d)), int'(expbuf[d][ex_rd[d]]));
                ex_rd[d]++;
            end
            if (lat_en) chk("wr_latency", d, cyc - rd_cyc[d], 2 + wr_idx[d]);
            wr_idx[d]++;
            wr_cnt[d]++;
        end
        if (rd) begin
            chk("pop_while_busy", d, int'(prev_busy[d]), 0);
            chk("pop_with_bytes_pending", d, ex_wr[d] - ex_rd[d], 0);
            chk("pop_from_nonempty", d, int'(kb_rd[d] < kb_wr[d]), 1);
            if (kb_rd[d] < kb_wr[d]) begin
                model_key(d, kbbuf[d][kb_rd[d]]);
                pop_pend[d] = 1'b1;
            end
            rd_cyc[d] = cyc;
            wr_idx[d] = 0;
            rd_cnt[d]++;
        end
        if (!bz) chk("col_idle", d, int'(o_col(d)), col_m[d]);
        prev_busy[d] = bz;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (pop_pend[d]) begin
                kb_rd[d]++;
                pop_pend[d] = 1'b0;
            end
        end
        #1;
        drive();
        #1;
        if (!reset) begin
            mon(0);
            mon(1);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = !o_busy(0) && !o_busy(1) && (kb_rd[0] >= kb_wr[0]) && (kb_rd[1] >= kb_wr[1])
                   && !pop_pend[0] && !pop_pend[1];
        end
        chk("reach_idle", 0, int'(done), 1);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_rd"},    d, int'(o_rd(d)),    0);
            chk({tag, "_wr"},    d, int'(o_wr(d)),    0);
            chk({tag, "_wdata"}, d, int'(o_wdata(d)), 0);
            chk({tag, "_busy"},  d, int'(o_busy(d)),  0);
            chk({tag, "_col"},   d, int'(o_col(d)),   0);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            kb_rd[d]     = kb_wr[d];
            ex_rd[d]     = ex_wr[d];
            col_m[d]     = 0;
            pop_pend[d]  = 1'b0;
            prev_busy[d] = 1'b0;
            wr_idx[d]    = 0;
        end
    endtask

    task automatic wait_wr80(input logic [7:0] b, input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            step();
            n++;
            seen = o_wr(1) && (o_wdata(1) == b);
        end
        chk(name, 1, int'(seen), 1);
    endtask

    initial begin
        int r0 [2];
        int w0 [2];
        int ws;
        int rs;

        vt[0]  = '{8'h41, 1, 1, 1, 1};
        vt[1]  = '{8'h0D, 0, 0, 2, 2};
        vt[2]  = '{8'h78, 1, 1, 1, 1};
        vt[3]  = '{8'h78, 2, 2, 1, 1};
        vt[4]  = '{8'h78, 3, 3, 1, 1};
        vt[5]  = '{8'h78, 4, 4, 1, 1};
        vt[6]  = '{8'h78, 1, 5, 3, 1};
        vt[7]  = '{8'h0D, 0, 0, 2, 2};
        vt[8]  = '{8'h61, 1, 1, 1, 1};
        vt[9]  = '{8'h62, 2, 2, 1, 1};
        vt[10] = '{8'h63, 3, 3, 1, 1};
        vt[11] = '{8'h08, 2, 2, 3, 3};
        vt[12] = '{8'h08, 1, 1, 3, 3};
        vt[13] = '{8'h08, 0, 0, 3, 3};
        vt[14] = '{8'h08, 0, 0, 0, 0};
        vt[15] = '{8'h00, 0, 0, 0, 0};
        vt[16] = '{8'h07, 0, 0, 0, 0};
        vt[17] = '{8'h7F, 0, 0, 0, 0};
        vt[18] = '{8'hFF, 0, 0, 0, 0};
        vt[19] = '{8'h7E, 1, 1, 1, 1};
        vt[20] = '{8'h20, 2, 2, 1, 1};
        vt[21] = '{8'h1F, 2, 2, 0, 0};

        tx_mode = 0;
        lat_en  = 1'b0;
        clear_model();
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        step();

        // Directed table with the UART FIFO always ready.
        lat_en = 1'b1;
        for (int i = 0; i < 22; i++) begin
            for (int d = 0; d < 2; d++) begin
                r0[d] = rd_cnt[d];
                w0[d] = wr_cnt[d];
            end
            push_key(vt[i].key);
            wait_idle(40);
            chk("tbl_col",    0, int'(o_col(0)), vt[i].col4);
            chk("tbl_col",    1, int'(o_col(1)), vt[i].col80);
            chk("tbl_writes", 0, wr_cnt[0] - w0[0], vt[i].w4);
            chk("tbl_writes", 1, wr_cnt[1] - w0[1], vt[i].w80);
            for (int d = 0; d < 2; d++) begin
                chk("tbl_pops",    d, rd_cnt[d] - r0[d], 1);
                chk("tbl_drained", d, ex_wr[d] - ex_rd[d], 0);
            end
        end
        lat_en = 1'b0;

        // Enter followed by 'q' with tx_full held for 10 cycles after the CR.
        push_key(8'h0D);
        push_key(8'h71);
        wait_wr80(8'h0D, "stall_cr_written");
        ws = wr_cnt[0] + wr_cnt[1];
        rs = rd_cnt[0] + rd_cnt[1];
        tx_mode = 1;
        repeat (10) step();
        chk("stall_writes", 1, wr_cnt[0] + wr_cnt[1] - ws, 0);
        chk("stall_pops",   1, rd_cnt[0] + rd_cnt[1] - rs, 0);
        chk("stall_busy",   1, int'(o_busy(1)), 1);
        tx_mode = 0;
        wait_idle(40);
        chk("stall_col", 0, int'(o_col(0)), 1);
        chk("stall_col", 1, int'(o_col(1)), 1);

        // Reset between the 0x08 and 0x20 of a backspace sequence.
        push_key(8'h62);
        push_key(8'h63);
        wait_idle(40);
        chk("pre_bs_col", 1, int'(o_col(1)), 3);
        push_key(8'h08);
        wait_wr80(8'h08, "bs_first_byte");
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_mid_seq");
        clear_model();
        step();
        step();
        push_key(8'h6B);
        @(negedge clk);
        reset = 1'b0;
        w0[1] = wr_cnt[1];
        wait_idle(40);
        chk("post_reset_col",    0, int'(o_col(0)), 1);
        chk("post_reset_col",    1, int'(o_col(1)), 1);
        chk("post_reset_writes", 1, wr_cnt[1] - w0[1], 1);

        // Randomised keys and UART back-pressure.
        tx_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 15 && (kb_wr[1] - kb_rd[1]) < 8) push_key(rand_key());
            step();
        end
        tx_mode = 0;
        wait_idle(400);
        for (int d = 0; d < 2; d++) begin
            chk("rand_drained", d, ex_wr[d] - ex_rd[d], 0);
            chk("rand_col",     d, int'(o_col(d)), col_m[d]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kb_echo_ctrl.md
KB_ECHO_CTRL -- requirements
Module: kb_echo_ctrl

Interface
REQ-001 Parameter MAX_COL, default 80, characters per terminal line before automatic CR LF wrap (2..127).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 kb_buf_empty  input  1  keyboard scan-code FIFO empty flag; 0 means ascii_code is valid (first-word fall-through).
REQ-005 ascii_code  input  8  ASCII of FIFO head key code.
REQ-006 rd_key_code  output  1  one-cycle pop strobe to keyboard FIFO.
REQ-007 tx_full  input  1  UART transmit FIFO full flag.
REQ-008 wr_uart  output  1  one-cycle write strobe to UART transmit FIFO.
REQ-009 w_data  output  8  byte written to UART, valid when wr_uart=1.
REQ-010 busy  output  1  high while a character or escape sequence is being emitted.
REQ-011 col  output  7  current column count, 0..MAX_COL.

Function
REQ-012 FSM states: IDLE, FETCH, EMIT, DONE; all outputs registered.
REQ-013 IDLE: when kb_buf_empty=0, latch ascii_code, assert rd_key_code for exactly one cycle, go FETCH.
REQ-014 rd_key_code SHALL only assert in IDLE; no second pop until the current sequence reaches DONE.
REQ-015 FETCH: classify latched byte, load emit sequence (max 5 bytes) and sequence length, go EMIT; byte 0x00 loads length 0 and goes DONE directly.
REQ-016 Printable byte (0x20..0x7E) with col<MAX_COL: sequence = {byte}; col increments by 1.
REQ-017 Printable byte with col=MAX_COL: sequence = {0x0D, 0x0A, byte}; col becomes 1.
REQ-018 Byte 0x0D (Enter): sequence = {0x0D, 0x0A}; col becomes 0.
REQ-019 Byte 0x08 (Backspace) with col>0: sequence = {0x08, 0x20, 0x08}; col decrements by 1.
REQ-020 Byte 0x08 with col=0: no bytes emitted; col stays 0.
REQ-021 Any other byte (0x01..0x1F except 0x08/0x0D, 0x7F..0xFF): dropped, col unchanged.
REQ-022 EMIT: per cycle, if tx_full=0 drive next sequence byte on w_data with wr_uart=1 and advance index; if tx_full=1 wr_uart=0, index held.
REQ-023 wr_uart SHALL never assert in a cycle where tx_full=1; back-to-back writes allowed when tx_full stays 0.
REQ-024 After the last sequence byte is written, go DONE; DONE returns to IDLE next cycle.
REQ-025 col update takes effect in the cycle the last sequence byte is written (or on entry to DONE for empty sequences).
REQ-026 busy=1 in FETCH, EMIT, DONE; busy=0 in IDLE.
REQ-027 Latency, tx_full=0: rd_key_code in cycle N, first wr_uart in cycle N+2, last in N+1+length.
REQ-028 Bytes arriving while busy remain in the keyboard FIFO; no key loss or reordering.

Reset
REQ-029 reset=1 asynchronously forces IDLE, rd_key_code=0, wr_uart=0, w_data=0x00, busy=0, col=0, sequence index=0.
REQ-030 Reset mid-sequence aborts remaining bytes; no partial-sequence resume after release.
REQ-031 First pop may occur no earlier than the second rising edge after reset deassertion.

Verification
REQ-032 Key 'A' (0x41), col=0, tx_full=0 -> one rd_key_code, one wr_uart w_data=0x41 two cycles later, col=1.
REQ-033 Enter (0x0D) at col=5 -> wr_uart 0x0D then 0x0A on consecutive cycles, col=0.
REQ-034 Backspace at col=3 -> 0x08, 0x20, 0x08 written, col=2; backspace at col=0 -> no wr_uart, col=0, one pop.
REQ-035 MAX_COL=4, five 'x' keys -> writes x,x,x,x,0x0D,0x0A,x; final col=1.
REQ-036 tx_full held high 10 cycles during Enter sequence -> wr_uart=0 throughout stall, sequence resumes intact after release, FIFO not popped until DONE.
REQ-037 Reset asserted between 0x08 and 0x20 of backspace sequence -> all outputs zero immediately, no further writes, next key processed from IDLE with col=0.
